fs_pipe_sub: RTL and testbench
==============================

// Module: fs_pipe_sub
// PURPOSE
//  Parametrised, pipelined WIDTH-bit full subtractor: diff = a - b - bin, borrow-out bout.
//  Splits the operands into STAGES slices of CHUNK bits, LSB slice first, one slice per
//  pipeline stage. The borrow ripples between stages through registers.
//  Valid/ready handshake on both sides. Replaces the combinational 16-bit subtractor
//  on high-fmax datapaths.
// PARAMETERS
//  WIDTH   16  operand/difference width; must satisfy WIDTH % STAGES == 0
//  STAGES  4   pipeline depth = number of slices; 1 <= STAGES <= WIDTH
//  CHUNK   WIDTH/STAGES  localparam, bits computed per stage (not overridable)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      reset; asynchronous assert, active-high
//  in_valid   in   1      a/b/bin are valid this cycle
//  in_ready   out  1      stage 0 can accept; transfer when in_valid & in_ready
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow-in
//  out_valid  out  1      diff/bout valid
//  out_ready  in   1      sink accepts; transfer when out_valid & out_ready
//  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//  bout       out  1      borrow-out, 1 when a < b + bin (unsigned)
//  busy       out  1      OR of all stage valid bits
// BEHAVIOUR
//  - Reset (async, rst=1): all stage valid bits, diff, bout and busy go to 0 immediately.
//    Data inside the pipeline is discarded. in_ready = 1 from the first edge after release.
//  - Per-stage state: v[k], a_hi/b_hi (slices not yet computed), d_lo (computed slices),
//    and br[k] (borrow into the next slice).
//  - Stage k computes slice k: {br, d} = a[k] - b[k] - br_in, with br_in = bin at stage 0.
//  - Per-stage advance: rdy[k] = !v[k] | rdy[k+1], with rdy[STAGES] = out_ready.
//    in_ready = rdy[0]. The ready chain is combinational; there is no bubble insertion.
//  - Stage k loads from stage k-1 when rdy[k] is 1. When the upstream is not valid it
//    loads v=0. When rdy[k]=0 the stage holds all fields unchanged.
//  - Latency: STAGES cycles from the accepting edge to out_valid=1 when there is no stall.
//  - Throughput: one result per cycle while out_ready=1.
//  - Stall: while out_valid & !out_ready, diff/bout/out_valid stay stable. Back-pressure
//    reaches in_ready only once every stage is full. No loss, no duplication, order kept.
//  - Simultaneous accept at stage 0 and emit at stage STAGES-1 in the same cycle is legal.
//    Both complete.
//  - diff and bout are registered outputs. diff and bout update only on an advancing edge
//    of the last stage.
//  - Boundaries: a=b, bin=0 gives diff=0, bout=0. a=0, b=0, bin=1 gives diff=all-ones,
//    bout=1. All-ones minus all-ones minus 1 gives all-ones, bout=1.
//  - STAGES=1 degenerates to a single registered full subtractor with a valid/ready slot.
// CONFIGURATION
//  FS_SAT_EN defined: unsigned floor saturation in the last stage. When the final borrow
//    is 1, diff is forced to 0 and bout still reports 1. Latency is unchanged.
//  FS_SAT_EN undefined: diff wraps modulo 2^WIDTH.
// STRUCTURE
//  fs_pkg: function fs_chunk(WIDTH, STAGES), and the elaboration check function
//    WIDTH % STAGES == 0. The check is invoked with $error at elaboration.
//  Sub-module fs_slice: combinational CHUNK-bit full subtractor (a, b, bin -> diff, bout).
//    Instantiated STAGES times in a generate loop.
//  The top holds the stage registers and the ready chain.
// TESTING  (WIDTH=16, STAGES=4, out_ready=1 unless stated)
//  1. a=0001 b=00F0 bin=1 -> 4 cycles later diff=FF10, bout=1.
//     a=0040 b=0001 bin=1 -> diff=003E, bout=0.
//  2. Back-to-back bin=0 (0001-00F0, 0002-1000, 0003-0030, 0040-0001) on consecutive
//     cycles -> FF11, F002, FFD3, 003F on consecutive cycles. Only 003F has bout=0.
//  3. Hold out_ready=0 with 5 inputs offered -> 4 accepted, in_ready drops.
//     out_valid is held with stable diff. Release -> all 4 emerge in order, then the 5th.
//  4. Assert rst with 3 operations in flight -> out_valid, busy, diff and bout go to 0
//     asynchronously. After release, nothing stale appears; a new op gives the right result.
//  5. Corners: 0000-0000-1 -> FFFF, bout=1. FFFF-FFFF-0 -> 0000, bout=0.
//     8000-0001-0 -> 7FFF, bout=0.
//  6. With FS_SAT_EN: 0001-00F0-0 -> diff=0000, bout=1. 0040-0001-0 -> 003F, unchanged.
//  Scoreboard in every test: compare against the reference model {bout,diff} = a - b - bin
//    in WIDTH+1 bits, in order.

Source files
------------

// File: rtl/fs_pkg.sv
// Sizing and configuration-check helpers shared by the pipelined full subtractor.
package fs_pkg;

   function automatic int unsigned fs_chunk(input int unsigned width, input int unsigned stages);
      return width / stages;
   endfunction

   function automatic bit fs_cfg_ok(input int unsigned width, input int unsigned stages);
      return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/fs_slice.sv
// Combinational W-bit full subtractor slice: {bout, diff} = a - b - bin.
module fs_slice #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         bin_i,
   output logic [W-1:0] diff_o,
   output logic         bout_o
);

   // The extra MSB of the widened difference is the borrow-out.
   assign {bout_o, diff_o} = {1'b0, a_i} - {1'b0, b_i} - (W+1)'(bin_i);

endmodule

// File: rtl/fs_pipe_sub.sv
// Pipelined WIDTH-bit full subtractor, one CHUNK-bit slice per stage, valid/ready on both sides.
// Optional FS_SAT_EN: clamp diff to zero in the last stage when the final borrow is set.
module fs_pipe_sub
   import fs_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy
);

   localparam int unsigned CHUNK = fs_chunk(WIDTH, STAGES);
   localparam int unsigned LAST  = STAGES - 1;

   if (!fs_cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
      $error("fs_pipe_sub: need 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
   end

   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] br_q, br_d;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  d_q [STAGES];
   logic [WIDTH-1:0]  d_d [STAGES];
   logic              busy_q, busy_d;

   logic [STAGES-1:0] rdy_c;
   logic [STAGES-1:0] up_v_c;
   logic [STAGES-1:0] up_br_c;
   logic [WIDTH-1:0]  up_a_c [STAGES];
   logic [WIDTH-1:0]  up_b_c [STAGES];
   logic [WIDTH-1:0]  up_d_c [STAGES];
   logic [CHUNK-1:0]  sl_diff_c [STAGES];
   logic [STAGES-1:0] sl_bout_c;

   // Upstream view of each stage: stage 0 sees the input port, stage k sees stage k-1.
   always_comb begin
      up_v_c[0]  = in_valid;
      up_br_c[0] = bin;
      up_a_c[0]  = a;
      up_b_c[0]  = b;
      up_d_c[0]  = '0;
      for (int k = 1; k < STAGES; k++) begin
         up_v_c[k]  = v_q[k-1];
         up_br_c[k] = br_q[k-1];
         up_a_c[k]  = a_q[k-1];
         up_b_c[k]  = b_q[k-1];
         up_d_c[k]  = d_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      fs_slice #(.W(CHUNK)) u_slice (
         .a_i    (up_a_c[k][k*CHUNK +: CHUNK]),
         .b_i    (up_b_c[k][k*CHUNK +: CHUNK]),
         .bin_i  (up_br_c[k]),
         .diff_o (sl_diff_c[k]),
         .bout_o (sl_bout_c[k])
      );
   end

   // Stage k may advance when any stage from k to the output is empty or the sink accepts.
   always_comb begin
      rdy_c = '0;
      for (int k = 0; k < STAGES; k++) begin
         rdy_c[k] = out_ready;
         for (int j = k; j < STAGES; j++) begin
            if (!v_q[j]) rdy_c[k] = 1'b1;
         end
      end
   end

   always_comb begin
      v_d  = v_q;
      br_d = br_q;
      a_d  = a_q;
      b_d  = b_q;
      d_d  = d_q;
      for (int k = 0; k < STAGES; k++) begin
         if (rdy_c[k]) begin
            v_d[k] = up_v_c[k];
            // Payload only moves with a valid token, so bubbles never disturb held data.
            if (up_v_c[k]) begin
               a_d[k]                   = up_a_c[k];
               b_d[k]                   = up_b_c[k];
               d_d[k]                   = up_d_c[k];
               d_d[k][k*CHUNK +: CHUNK] = sl_diff_c[k];
               br_d[k]                  = sl_bout_c[k];
            end
         end
      end
`ifdef FS_SAT_EN
      if (rdy_c[LAST] && up_v_c[LAST] && sl_bout_c[LAST]) d_d[LAST] = '0;
`endif
      busy_d = |v_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q    <= '0;
         br_q   <= '0;
         busy_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            d_q[k] <= '0;
         end
      end else begin
         v_q    <= v_d;
         br_q   <= br_d;
         busy_q <= busy_d;
         a_q    <= a_d;
         b_q    <= b_d;
         d_q    <= d_d;
      end
   end

   assign in_ready  = rdy_c[0];
   assign out_valid = v_q[LAST];
   assign diff      = d_q[LAST];
   assign bout      = br_q[LAST];
   assign busy      = busy_q;

endmodule

// File: tb/tb_fs_pipe_sub.sv
// Self-checking bench for fs_pipe_sub: directed, corner and randomized traffic against an integer model.
module tb_fs_pipe_sub;

   localparam int unsigned W = 16;
   localparam int unsigned S = 4;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      logic         bo;
      logic [W-1:0] d;
   } vec_t;

   logic         clk, rst, in_valid, in_ready, bin, out_valid, out_ready, bout, busy;
   logic [W-1:0] a, b, diff;

   int checks   = 0;
   int failures = 0;
   logic [W:0] exp_q [$];

   fs_pipe_sub #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .bout(bout), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // Reference: plain signed integer arithmetic; negative result means borrow.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      int r;
      r = int'(x) - int'(y) - int'(c);
      if (r < 0) begin
`ifdef FS_SAT_EN
         return {1'b1, {W{1'b0}}};
`else
         return {1'b1, W'(r + (1 << W))};
`endif
      end
      return {1'b0, W'(r)};
   endfunction

   // Turns a wrap-mode expected pair into the expected pair for the current build.
   function automatic logic [W:0] exp_of(input logic bo, input logic [W-1:0] d);
`ifdef FS_SAT_EN
      if (bo) return {1'b1, {W{1'b0}}};
`endif
      return {bo, d};
   endfunction

   // One clock: sample handshakes just before the edge, update the model queue, return at negedge.
   task automatic tick(output bit acc, output bit em, output logic [W:0] got);
      logic [W:0] m;
      #1;
      acc = in_valid && in_ready;
      em  = out_valid && out_ready;
      got = {bout, diff};
      m   = model(a, b, bin);
      @(posedge clk);
      if (acc) exp_q.push_back(m);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, busy, bout, diff} !== '0) begin
         failures++;
         $display("FAIL reset_state got out_valid=%b busy=%b bout=%b diff=%h exp all zero", out_valid, busy, bout, diff);
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got=%b exp=1", in_ready);
      end
   endtask

   task automatic test_directed();
      bit acc, em;
      logic [W:0] got;
      vec_t v [2];
      v[0] = '{16'h0001, 16'h00F0, 1'b1, 1'b1, 16'hFF10};
      v[1] = '{16'h0040, 16'h0001, 1'b1, 1'b0, 16'h003E};
      out_ready = 1'b1;
      for (int t = 0; t < 2; t++) begin
         a = v[t].a; b = v[t].b; bin = v[t].c; in_valid = 1'b1;
         tick(acc, em, got);
         in_valid = 1'b0;
         checks++;
         if (!acc) begin failures++; $display("FAIL directed_accept idx=%0d got=0 exp=1", t); end
         for (int i = 0; i < int'(S) - 1; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
               failures++; $display("FAIL directed_latency_early idx=%0d cycle=%0d got=%b exp=0", t, i, out_valid);
            end
            tick(acc, em, got);
         end
         checks++;
         if (out_valid !== 1'b1) begin failures++; $display("FAIL directed_latency idx=%0d got=%b exp=1", t, out_valid); end
         checks++;
         if ({bout, diff} !== exp_of(v[t].bo, v[t].d)) begin
            failures++; $display("FAIL directed_value idx=%0d got=%h exp=%h", t, {bout, diff}, exp_of(v[t].bo, v[t].d));
         end
         tick(acc, em, got);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
   endtask

   task automatic test_back_to_back();
      bit acc, em;
      logic [W:0] got;
      int n = 0;
      vec_t v [4];
      v[0] = '{16'h0001, 16'h00F0, 1'b0, 1'b1, 16'hFF11};
      v[1] = '{16'h0002, 16'h1000, 1'b0, 1'b1, 16'hF002};
      v[2] = '{16'h0003, 16'h0030, 1'b0, 1'b1, 16'hFFD3};
      v[3] = '{16'h0040, 16'h0001, 1'b0, 1'b0, 16'h003F};
      out_ready = 1'b1;
      for (int c = 0; c < 20 && n < 4; c++) begin
         in_valid = (c < 4);
         if (c < 4) begin a = v[c].a; b = v[c].b; bin = v[c].c; end
         tick(acc, em, got);
         if (em) begin
            checks++;
            if (got !== exp_of(v[n].bo, v[n].d)) begin
               failures++; $display("FAIL b2b_value idx=%0d got=%h exp=%h", n, got, exp_of(v[n].bo, v[n].d));
            end
            checks++;
            if (c != int'(S) + n) begin failures++; $display("FAIL b2b_timing idx=%0d got_cycle=%0d exp_cycle=%0d", n, c, int'(S) + n); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (n != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", n); end
   endtask

   task automatic test_stall();
      bit acc, em;
      logic [W:0] got, held, e;
      logic [W-1:0] sa [5];
      logic [W-1:0] sb [5];
      logic sc [5];
      int idx = 0;
      int n   = 0;
      for (int i = 0; i < 5; i++) begin sa[i] = W'($urandom); sb[i] = W'($urandom); sc[i] = 1'($urandom); end
      out_ready = 1'b0;
      held = '0;
      for (int c = 0; c < 10; c++) begin
         in_valid = (idx < 5);
         if (idx < 5) begin a = sa[idx]; b = sb[idx]; bin = sc[idx]; end
         tick(acc, em, got);
         if (acc) idx++;
         if (c == int'(S) - 1) begin
            held = {bout, diff};
            checks++;
            if (exp_q.size() == 0 || held !== exp_q[0]) begin
               failures++; $display("FAIL stall_first got=%h exp=%h", held, (exp_q.size() != 0) ? exp_q[0] : 'x);
            end
         end
         if (c >= int'(S)) begin
            checks++;
            if (out_valid !== 1'b1 || {bout, diff} !== held) begin
               failures++; $display("FAIL stall_hold cycle=%0d got=%b/%h exp=1/%h", c, out_valid, {bout, diff}, held);
            end
         end
      end
      checks++;
      if (idx != int'(S) || in_ready !== 1'b0) begin
         failures++; $display("FAIL stall_accept got accepted=%0d in_ready=%b exp accepted=%0d in_ready=0", idx, in_ready, S);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 30 && n < 5; c++) begin
         in_valid = (idx < 5);
         if (idx < 5) begin a = sa[idx]; b = sb[idx]; bin = sc[idx]; end
         tick(acc, em, got);
         if (acc) idx++;
         if (em) begin
            if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL stall_drain idx=%0d got=%h exp=%h", n, got, e); end
            n++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (n != 5) begin failures++; $display("FAIL stall_count got=%0d exp=5", n); end
   endtask

   task automatic test_reset_midflight();
      bit acc, em;
      logic [W:0] got;
      int n = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = (i < 3); a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
         tick(acc, em, got);
      end
      in_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b1) begin
         failures++; $display("FAIL flight_state got busy=%b out_valid=%b exp 1/1", busy, out_valid);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({out_valid, busy, bout, diff} !== '0) begin
         failures++; $display("FAIL async_reset got out_valid=%b busy=%b bout=%b diff=%h exp all zero", out_valid, busy, bout, diff);
      end
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick(acc, em, got);
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL stale_after_reset cycle=%0d got out_valid=%b busy=%b exp 0/0", c, out_valid, busy);
         end
      end
      a = 16'h1234; b = 16'h0235; bin = 1'b1; in_valid = 1'b1;
      tick(acc, em, got);
      in_valid = 1'b0;
      for (int c = 0; c < 10 && n == 0; c++) begin
         tick(acc, em, got);
         if (em) begin
            checks++;
            if (got !== {1'b0, 16'h0FFE}) begin failures++; $display("FAIL post_reset_op got=%h exp=%h", got, {1'b0, 16'h0FFE}); end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n++;
         end
      end
      checks++;
      if (n != 1) begin failures++; $display("FAIL post_reset_count got=%0d exp=1", n); end
   endtask

   task automatic test_corners();
      bit acc, em;
      logic [W:0] got;
      int n = 0;
      vec_t v [7];
      v[0] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF};
      v[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'h0000};
      v[2] = '{16'h8000, 16'h0001, 1'b0, 1'b0, 16'h7FFF};
      v[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF};
      v[4] = '{16'h1234, 16'h1234, 1'b0, 1'b0, 16'h0000};
      v[5] = '{16'h0001, 16'h00F0, 1'b0, 1'b1, 16'hFF11};
      v[6] = '{16'h0040, 16'h0001, 1'b0, 1'b0, 16'h003F};
      out_ready = 1'b1;
      for (int c = 0; c < 30 && n < 7; c++) begin
         in_valid = (c < 7);
         if (c < 7) begin a = v[c].a; b = v[c].b; bin = v[c].c; end
         tick(acc, em, got);
         if (em) begin
            checks++;
            if (got !== exp_of(v[n].bo, v[n].d)) begin
               failures++; $display("FAIL corner idx=%0d got=%h exp=%h", n, got, exp_of(v[n].bo, v[n].d));
            end
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n++;
         end
      end
      in_valid = 1'b0;
      checks++;
      if (n != 7) begin failures++; $display("FAIL corner_count got=%0d exp=7", n); end
   endtask

   task automatic test_random();
      bit acc, em, stall;
      logic [W:0] got, prev, e;
      for (int c = 0; c < 300; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a   = W'($urandom);
         b   = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
         bin = 1'($urandom);
         #1;
         stall = out_valid && !out_ready;
         prev  = {bout, diff};
         tick(acc, em, got);
         if (em) begin
            if (exp_q.size() == 0) e = 'x; else e = exp_q.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL rand_value cycle=%0d got=%h exp=%h", c, got, e); end
         end
         if (stall) begin
            checks++;
            if (out_valid !== 1'b1 || {bout, diff} !== prev) begin
               failures++; $display("FAIL rand_hold cycle=%0d got=%b/%h exp=1/%h", c, out_valid, {bout, diff}, prev);
            end
         end
         checks++;
         if (busy !== (exp_q.size() != 0)) begin
            failures++; $display("FAIL rand_busy cycle=%0d got=%b exp=%b", c, busy, exp_q.size() != 0);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
         tick(acc, em, got);
         if (em) begin
            e = exp_q.pop_front();
            checks++;
            if (got !== e) begin failures++; $display("FAIL rand_drain got=%h exp=%h", got, e); end
         end
      end
      checks++;
      if (exp_q.size() != 0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL rand_empty got pending=%0d out_valid=%b exp 0/0", exp_q.size(), out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_stall();
      test_reset_midflight();
      test_corners();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
